sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in parallel-out deserializer; the receive-side counterpart of the team's PISO shift register.
- Captures one bit per enabled clock, MSB first, into a WIDTH-bit word.
- Presents each completed word on a registered parallel port with a valid/ready handshake and sticky overrun detection.
- Sits between a serial link (driven by the PISO's serial_out) and downstream parallel logic.

Parameters:
- WIDTH, 4, data word width in bits; legal range ≥2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial data bit, MSB of word first.
- shift_en  input  1  sample serial_in on this edge.
- sync_clr  input  1  synchronous abort of the partial frame.
- out_ready  input  1  consumer accepts parallel_out on this edge.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- parallel_out  output  WIDTH  last completed word.
- out_valid  output  1  parallel_out holds an unconsumed word.
- busy  output  1  partial frame in progress (bit_cnt != 0).
- overrun  output  1  sticky; a completed word was dropped.
- parity_err  output  1  parity check result (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): shift_reg=0, bit_cnt=0, parallel_out=0, out_valid=0, overrun=0, parity_err=0, busy=0. Reset mid-frame discards all partial bits.
- Internal state: shift_reg[WIDTH-1:0] and bit_cnt, counting 0..FRAME_LEN-1 (FRAME_LEN=WIDTH; WIDTH+1 with parity).
- Shift (shift_en=1, sync_clr=0):
  - shift_reg <= {shift_reg[WIDTH-2:0], serial_in}.
  - bit_cnt increments.
- shift_en=0: hold all shift state. Gaps between bits are legal and unlimited.
- Frame completion: on the edge that samples the last frame bit (bit_cnt==FRAME_LEN-1):
  - bit_cnt <= 0.
  - The completed word is {shift_reg[WIDTH-2:0], serial_in} (no parity) or shift_reg (parity).
  - If the output slot is free, or freed this edge (!out_valid or out_ready): parallel_out <= word, out_valid <= 1.
  - Otherwise: word dropped, parallel_out unchanged, overrun <= 1.
- Latency: parallel_out and out_valid are visible immediately after the completing edge, with zero extra cycles.
- Handshake:
  - Transfer occurs on an edge where out_valid && out_ready.
  - After transfer, out_valid clears unless a word completes on the same edge; in that case the new word is loaded and out_valid stays 1, with no overrun.
  - out_ready while !out_valid has no effect.
  - parallel_out is retained after transfer; it is not zeroed.
- sync_clr:
  - Priority over shift_en.
  - Clears shift_reg and bit_cnt.
  - Does not affect out_valid, parallel_out or overrun.
- Overrun:
  - Sticky until clr_overrun or reset.
  - If clr_overrun and a new overrun occur on the same edge, the set wins.
- busy: combinational (bit_cnt != 0).
- Bit order: the first sampled bit lands in parallel_out[WIDTH-1].

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit.
  - On the completing (parity) edge, the parity_err value computed as ^shift_reg ^ serial_in is loaded together with parallel_out.
  - parity_err follows the same load/hold/drop rules as parallel_out.
  - The word is delivered even on a parity error.
- Undefined:
  - FRAME_LEN=WIDTH.
  - parity_err tied to 0.
  - Port list is unchanged.

Decomposition:
- Package sipo_pkg:
  - SIPO_DEFAULT_WIDTH=4.
  - Function cnt_w(frame_len) returning $clog2(frame_len), minimum 1, for bit_cnt sizing.
- Sub-module sipo_bit_counter:
  - Parameterised modulo-FRAME_LEN counter.
  - Inputs: en, clr.
  - Outputs: count, last (count==FRAME_LEN-1).
- Top level holds the shift register, output slot and flags.

Test Plan:
1. Reset: drive rst_n=0 for 2 cycles after 2 bits shifted -> all outputs 0 immediately. Release, shift 1,1,0,1 -> parallel_out=4'b1101.
2. Basic frame: with out_ready=0, shift 1,1,0,1 on consecutive edges -> busy=1 after bits 1–3; after the 4th edge, parallel_out=1101, out_valid=1, busy=0. Pulse out_ready -> out_valid=0, parallel_out still 1101.
3. Overrun: hold out_ready=0 with 1101 pending, shift 0,1,1,0 -> overrun=1, parallel_out=1101, out_valid=1. Pulse clr_overrun -> overrun=0.
4. Back-to-back: out_ready=1 constant, shift 1010 then 0101 with no gaps -> out_valid high after edges 4 and 8, values 1010 then 0101, overrun stays 0. Also cover completion coincident with acceptance.
5. Gaps/abort: shift 1,0, then sync_clr, then 0,0,1,1 with idle cycles between bits -> parallel_out=0011, no spurious valid.
6. SIPO_PARITY_EN defined:
   - Shift 1101 then parity 1 -> parity_err=0.
   - Shift 1101 then parity 0 -> parity_err=1, parallel_out=1101.
   - out_valid asserts only after the 5th edge.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and sizing helpers for the serial-in parallel-out deserializer.
package sipo_pkg;

  localparam int SIPO_DEFAULT_WIDTH = 4;

  // Bit-counter width for a frame of frame_len bits; never narrower than 1.
  function automatic int cnt_w(input int frame_len);
    int w;
    w = $clog2(frame_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-FRAME_LEN bit position counter; clr has priority over en.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int FRAME_LEN = SIPO_DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
  output logic [cnt_w(FRAME_LEN)-1:0]  count,
  output logic                         last
);

  localparam int CW = cnt_w(FRAME_LEN);
  localparam logic [CW-1:0] LAST_VAL = CW'(FRAME_LEN - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = (count_reg == LAST_VAL) ? '0 : count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == LAST_VAL);

endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer with valid/ready output slot and sticky overrun.
// Define SIPO_PARITY_EN to append one even-parity bit per frame and report parity_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             sync_clr,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  // Without parity the word MSB-to-LSB is complete one bit early, so only
  // FRAME_LEN-1 bits ever need to be held; the last one arrives on serial_in.
  localparam int SR_W = FRAME_LEN - 1;

  logic [SR_W-1:0]             shift_reg;
  logic [SR_W-1:0]             shift_next;
  logic [cnt_w(FRAME_LEN)-1:0] bit_cnt;
  logic                        bit_last;
  logic                        do_shift;
  logic                        complete;
  logic                        slot_free;
  logic [WIDTH-1:0]            word;
  logic                        par_err_next;

  logic [WIDTH-1:0] parallel_out_reg;
  logic             out_valid_reg;
  logic             overrun_reg;
  logic             parity_err_reg;

  assign do_shift  = shift_en && !sync_clr;
  assign complete  = do_shift && bit_last;
  assign slot_free = !out_valid_reg || out_ready;

  assign shift_next[0] = serial_in;
  generate
    for (genvar gi = 1; gi < SR_W; gi++) begin : g_shift
      assign shift_next[gi] = shift_reg[gi-1];
    end
  endgenerate

`ifdef SIPO_PARITY_EN
  assign word         = shift_reg;
  assign par_err_next = ^shift_reg ^ serial_in;
`else
  assign word         = {shift_reg, serial_in};
  assign par_err_next = 1'b0;
`endif

  sipo_bit_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (do_shift),
    .clr   (sync_clr),
    .count (bit_cnt),
    .last  (bit_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (sync_clr) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_next;
    end
  end

  // Output slot: a completing word may refill the slot on the same edge it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parallel_out_reg <= '0;
      out_valid_reg    <= 1'b0;
      overrun_reg      <= 1'b0;
      parity_err_reg   <= 1'b0;
    end else begin
      if (complete && slot_free) begin
        parallel_out_reg <= word;
        parity_err_reg   <= par_err_next;
        out_valid_reg    <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (complete && !slot_free) begin
        overrun_reg <= 1'b1;
      end else if (clr_overrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign parallel_out = parallel_out_reg;
  assign out_valid    = out_valid_reg;
  assign overrun      = overrun_reg;
  assign parity_err   = parity_err_reg;
  assign busy         = (bit_cnt != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (WIDTH=4); parity cases run when SIPO_PARITY_EN is defined.
module tb_sipo_deserializer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             serial_in;
  logic             shift_en;
  logic             sync_clr;
  logic             out_ready;
  logic             clr_overrun;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  int checks = 0;
  int errors = 0;

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_in    (serial_in),
    .shift_en     (shift_en),
    .sync_clr     (sync_clr),
    .out_ready    (out_ready),
    .clr_overrun  (clr_overrun),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    shift_en  = 1'b1;
    tick();
    shift_en  = 1'b0;
  endtask

  // Sends one frame MSB first (plus even parity when enabled), gap idle cycles after each bit.
  // ready_on_last raises out_ready together with the completing bit.
  task automatic send_frame(input logic [WIDTH-1:0] w, input int gap, input logic ready_on_last);
    int nbits;
    logic [WIDTH:0] bits;
`ifdef SIPO_PARITY_EN
    nbits = WIDTH + 1;
    bits  = {w, ^w};
`else
    nbits = WIDTH;
    bits  = {1'b0, w};
`endif
    for (int i = nbits - 1; i >= 0; i--) begin
      serial_in = bits[i];
      shift_en  = 1'b1;
      if (i == 0 && ready_on_last) out_ready = 1'b1;
      tick();
      if (gap > 0) begin
        shift_en = 1'b0;
        repeat (gap) tick();
      end
    end
    shift_en = 1'b0;
    $display("frame %b sent: parallel_out=%b out_valid=%0b overrun=%0b", w, parallel_out, out_valid, overrun);
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; serial_in = 1'b0; shift_en = 1'b0; sync_clr = 1'b0;
    out_ready = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    chk("reset_po", 32'(parallel_out), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    chk("reset_parity", 32'(parity_err), 32'h0);
    rst_n = 1'b1;

    // 1: asynchronous reset mid-frame
    send_bit(1'b1); send_bit(1'b1);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy), 32'h0);
    chk("async_reset_valid", 32'(out_valid), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    send_frame(4'b1101, 0, 1'b0);
    chk("t1_po", 32'(parallel_out), 32'hD);
    chk("t1_valid", 32'(out_valid), 32'h1);
    pulse_ready();

    // 2: basic frame with busy tracking
    send_bit(1'b1); chk("t2_busy1", 32'(busy), 32'h1);
    send_bit(1'b1); chk("t2_busy2", 32'(busy), 32'h1);
    send_bit(1'b0); chk("t2_busy3", 32'(busy), 32'h1);
    chk("t2_no_early_valid", 32'(out_valid), 32'h0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b1); chk("t2_busy4", 32'(busy), 32'h1);
    chk("t2_no_valid_at_4", 32'(out_valid), 32'h0);
    send_bit(1'b1);
`else
    send_bit(1'b1);
`endif
    chk("t2_po", 32'(parallel_out), 32'hD);
    chk("t2_valid", 32'(out_valid), 32'h1);
    chk("t2_busy_done", 32'(busy), 32'h0);
    chk("t2_parity", 32'(parity_err), 32'h0);
    pulse_ready();
    chk("t2_valid_cleared", 32'(out_valid), 32'h0);
    chk("t2_po_retained", 32'(parallel_out), 32'hD);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t2_ready_idle", 32'(out_valid), 32'h0);

    // 3: overrun when the slot is full
    send_frame(4'b1101, 0, 1'b0);
    send_frame(4'b0110, 0, 1'b0);
    chk("t3_overrun", 32'(overrun), 32'h1);
    chk("t3_po_kept", 32'(parallel_out), 32'hD);
    chk("t3_valid", 32'(out_valid), 32'h1);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    chk("t3_overrun_clr", 32'(overrun), 32'h0);
    pulse_ready();

    // 4: back-to-back frames with out_ready held high
    out_ready = 1'b1;
    send_frame(4'b1010, 0, 1'b0);
    chk("t4_po1", 32'(parallel_out), 32'hA);
    chk("t4_valid1", 32'(out_valid), 32'h1);
    send_frame(4'b0101, 0, 1'b0);
    chk("t4_po2", 32'(parallel_out), 32'h5);
    chk("t4_valid2", 32'(out_valid), 32'h1);
    chk("t4_no_overrun", 32'(overrun), 32'h0);
    // completion coincident with acceptance of a pending word
    out_ready = 1'b0;
    send_frame(4'b1001, 0, 1'b1);
    out_ready = 1'b0;
    chk("t4_coinc_po", 32'(parallel_out), 32'h9);
    chk("t4_coinc_valid", 32'(out_valid), 32'h1);
    chk("t4_coinc_overrun", 32'(overrun), 32'h0);
    pulse_ready();

    // 5: abort then gapped frame; sync_clr beats a simultaneous shift
    send_bit(1'b1); send_bit(1'b0);
    sync_clr = 1'b1; shift_en = 1'b1; serial_in = 1'b1;
    tick();
    sync_clr = 1'b0; shift_en = 1'b0;
    chk("t5_abort_busy", 32'(busy), 32'h0);
    chk("t5_abort_valid", 32'(out_valid), 32'h0);
    send_frame(4'b0011, 2, 1'b0);
    chk("t5_po", 32'(parallel_out), 32'h3);
    chk("t5_valid", 32'(out_valid), 32'h1);
    pulse_ready();

`ifdef SIPO_PARITY_EN
    // 6: parity error is reported but the word is still delivered
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t6_no_valid_at_4", 32'(out_valid), 32'h0);
    send_bit(1'b0);
    chk("t6_valid", 32'(out_valid), 32'h1);
    chk("t6_po", 32'(parallel_out), 32'hD);
    chk("t6_parity_err", 32'(parity_err), 32'h1);
    pulse_ready();
    send_frame(4'b1101, 0, 1'b0);
    chk("t6_parity_ok", 32'(parity_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
